// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and hex-to-segment decode for the
// time-multiplexed 7-segment display driver.
package seg7_pkg;

    // All segments dark in the internal active-low form {dp, g..a}.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low gfedcba patterns, entry n at index n (0..F).
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // IDLE: display disabled; BLANK: anti-ghost gap after a digit advance;
    // SCAN: current digit driven.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SCAN  = 2'd2
    } scan_state_e;

    function automatic logic [6:0] hex_decode(input logic [3:0] code);
        return HEX_TABLE[code];
    endfunction

    // Clock cycles per digit slot.
    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display bus: character/control inputs from the decoder side and the
// registered pin-side outputs of the scan driver.
interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   seg_en;
    logic                    frame_done;

    modport master (
        output en, digits, blank, dp, load,
        input  seg_out, seg_en, frame_done
    );

    modport slave (
        input  en, digits, blank, dp, load,
        output seg_out, seg_en, frame_done
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex code to active-low gfedcba segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);
    // Table lookup shared with the package so every user decodes identically.
    always_comb seg_n = hex_decode(code);
endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment scan driver: refresh prescaler, per-digit
// anti-ghost blanking, frame-synchronous shadow registers, registered pins.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYC      = 2,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_EN  = 1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_display_if.slave bus
);
    localparam int DIV   = calc_div(CLK_HZ, SCAN_HZ);
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BC_W  = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  BC_RELOAD = BC_W'(BLANK_CYC);
    // The IDLE->run cycle is itself dark, so startup loads one less.
    localparam logic [BC_W-1:0]  BC_START  = (BLANK_CYC > 0) ? BC_W'(BLANK_CYC - 1) : '0;

    localparam logic [7:0]            SEG_DARK = (ACTIVE_LOW_SEG != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] EN_DARK  = (ACTIVE_LOW_EN != 0) ? '1 : '0;

    scan_state_e             state_q, state_d;
    logic [PS_W-1:0]         prescaler;
    logic [IDX_W-1:0]        idx;
    logic [BC_W-1:0]         blank_cnt;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_dp;

    logic                    tick, wrap, capture;
    logic [3:0]              cur_code;
    logic [6:0]              dec_seg;
    logic [7:0]              seg_p0;
    logic [NUM_DIGITS-1:0]   en_p0;
    logic [7:0]              seg_out_p1;
    logic [NUM_DIGITS-1:0]   seg_en_p1;
    logic                    frame_done_p1;

    assign tick     = bus.en && (prescaler == PS_LAST);
    assign wrap     = tick && (idx == IDX_LAST);
    // Running: only at a frame boundary. Stopped: nothing is on screen, so load at once.
    assign capture  = bus.en ? (wrap && (pending || bus.load)) : bus.load;
    assign cur_code = sh_digits[{idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .code  (cur_code),
        .seg_n (dec_seg)
    );

    // Scan state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state: blank gap after every advance, then drive until the next tick.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = (BC_START != '0) ? ST_BLANK : ST_SCAN;
                ST_BLANK: begin
                    if (tick)                       state_d = (BLANK_CYC > 0) ? ST_BLANK : ST_SCAN;
                    else if (blank_cnt == BC_W'(1)) state_d = ST_SCAN;
                end
                ST_SCAN:  if (tick && BLANK_CYC > 0) state_d = ST_BLANK;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler, digit index and blank counter; all parked at zero while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            idx       <= '0;
            blank_cnt <= '0;
        end else if (!bus.en) begin
            prescaler <= '0;
            idx       <= '0;
            blank_cnt <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                blank_cnt <= BC_RELOAD;
            end else if (state_q == ST_IDLE) begin
                blank_cnt <= BC_START;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
            end
        end
    end

    // Shadow copy of the display content, swapped only between frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= 1'b0;
            sh_digits <= '0;
            sh_blank  <= '0;
            sh_dp     <= '0;
        end else if (capture) begin
            pending   <= 1'b0;
            sh_digits <= bus.digits;
            sh_blank  <= bus.blank;
            sh_dp     <= bus.dp;
        end else if (bus.load) begin
            pending   <= 1'b1;
        end
    end

    // Pin pattern for the current digit, built active-low then polarity-adjusted.
    always_comb begin
        logic [7:0]            seg_lo;
        logic [NUM_DIGITS-1:0] onehot;
        seg_lo = SEG_OFF;
        onehot = '0;
        if (bus.en && state_q == ST_SCAN) begin
            onehot = NUM_DIGITS'(1) << idx;
            if (!sh_blank[idx]) seg_lo = {~sh_dp[idx], dec_seg};
        end
        seg_p0 = (ACTIVE_LOW_SEG != 0) ? seg_lo : ~seg_lo;
        en_p0  = (ACTIVE_LOW_EN != 0) ? ~onehot : onehot;
    end

    // ---- stage p0 -> p1: registered pin outputs ----
    // Output registers, so the pins never glitch on decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out_p1    <= SEG_DARK;
            seg_en_p1     <= EN_DARK;
            frame_done_p1 <= 1'b0;
        end else begin
            seg_out_p1    <= seg_p0;
            seg_en_p1     <= en_p0;
            frame_done_p1 <= wrap;
        end
    end

    assign bus.seg_out    = seg_out_p1;
    assign bus.seg_en     = seg_en_p1;
    assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: 4 digits, DIV=10, BLANK_CYC=2, active-low.
module tb_seg7_scan_display;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_pass = 0;
    int   pulses;

    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_display_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_display #(
        .NUM_DIGITS     (4),
        .CLK_HZ         (1000),
        .SCAN_HZ        (100),
        .BLANK_CYC      (2),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_EN  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.digits = '0;
        bus.blank  = '0;
        bus.dp     = '0;
        bus.load   = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_seg", 32'(bus.seg_out), 32'hFF);
        chk("rst_en", 32'(bus.seg_en), 32'hF);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);
        step(2);
        rst = 1'b1;

        // Load while stopped (immediate), then run.
        bus.digits = 16'h4321;
        bus.load   = 1'b1;
        step(1);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        step(1); chk("start_blank0_en", 32'(bus.seg_en), 32'hF);
        step(1); chk("start_blank1_seg", 32'(bus.seg_out), 32'hFF);
        step(1); chk("d0_en", 32'(bus.seg_en), 32'hE);
                 chk("d0_seg", 32'(bus.seg_out), 32'hF9);
        step(7); chk("d0_last_seg", 32'(bus.seg_out), 32'hF9);
        step(1); chk("gap_en", 32'(bus.seg_en), 32'hF);
        step(2); chk("d1_en", 32'(bus.seg_en), 32'hD);
                 chk("d1_seg", 32'(bus.seg_out), 32'hA4);
        step(10); chk("d2_en", 32'(bus.seg_en), 32'hB);
                  chk("d2_seg", 32'(bus.seg_out), 32'hB0);
        step(10); chk("d3_en", 32'(bus.seg_en), 32'h7);
                  chk("d3_seg", 32'(bus.seg_out), 32'h99);
                  chk("fd_before_wrap", 32'(bus.frame_done), 32'h0);
        step(7); chk("fd_pulse", 32'(bus.frame_done), 32'h1);
        step(1); chk("fd_single", 32'(bus.frame_done), 32'h0);

        // Tear-free: load while digit2 is on screen.
        step(20);
        bus.digits = 16'hABCD;
        bus.load   = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(1);  chk("torn_d2_old", 32'(bus.seg_out), 32'hB0);
        step(10); chk("torn_d3_old", 32'(bus.seg_out), 32'h99);
        step(10); chk("new_d0_seg", 32'(bus.seg_out), 32'hA1);
                  chk("new_d0_en", 32'(bus.seg_en), 32'hE);

        // Blank and decimal point, plus one frame pulse per 40 cycles.
        bus.digits = 16'h0008;
        bus.blank  = 4'b0010;
        bus.dp     = 4'b0001;
        bus.load   = 1'b1;
        step(1);
        bus.load = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 39; i++) begin
            step(1);
            pulses += int'(bus.frame_done);
        end
        chk("fd_per_frame", 32'(pulses), 32'd1);
        chk("dp_d0_seg", 32'(bus.seg_out), 32'h00);
        chk("dp_d0_en", 32'(bus.seg_en), 32'hE);
        step(10); chk("blank_d1_en", 32'(bus.seg_en), 32'hD);
                  chk("blank_d1_seg", 32'(bus.seg_out), 32'hFF);
        step(10); chk("d2_zero_seg", 32'(bus.seg_out), 32'hC0);
        step(10); chk("d3_zero_seg", 32'(bus.seg_out), 32'hC0);

        // Load exactly on the wrapping tick.
        bus.digits = 16'h5555;
        bus.blank  = '0;
        bus.dp     = '0;
        step(6);
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(3); chk("coinc_d0_seg", 32'(bus.seg_out), 32'h92);
                 chk("coinc_d0_en", 32'(bus.seg_en), 32'hE);

        // Disable for 5 cycles with an immediate load in the middle.
        bus.en = 1'b0;
        step(1); chk("off_seg", 32'(bus.seg_out), 32'hFF);
                 chk("off_en", 32'(bus.seg_en), 32'hF);
        bus.digits = 16'h0006;
        bus.load   = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(3); chk("off_hold_en", 32'(bus.seg_en), 32'hF);
                 chk("off_fd", 32'(bus.frame_done), 32'h0);
        bus.en = 1'b1;
        step(1); chk("restart_blank0", 32'(bus.seg_en), 32'hF);
        step(1); chk("restart_blank1", 32'(bus.seg_en), 32'hF);
        step(1); chk("restart_d0_en", 32'(bus.seg_en), 32'hE);
                 chk("restart_d0_seg", 32'(bus.seg_out), 32'h82);

        // Every hex code on digit0.
        for (int v = 0; v < 16; v++) begin
            bus.en     = 1'b0;
            bus.digits = 16'(v);
            bus.load   = 1'b1;
            step(1);
            bus.load = 1'b0;
            bus.en   = 1'b1;
            step(3);
            chk($sformatf("hex_%0h", v), 32'(bus.seg_out[6:0]), 32'(HEX7[v]));
        end

        // Asynchronous reset in the middle of a scan.
        step(5);
        rst = 1'b0;
        #1;
        chk("midrst_seg", 32'(bus.seg_out), 32'hFF);
        chk("midrst_en", 32'(bus.seg_en), 32'hF);
        chk("midrst_fd", 32'(bus.frame_done), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
